// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and baud divider helper
package uart_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int OS_RATE = 16;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP = 3'd4;
  function automatic int div_num(input int baud);
    return CLK_HZ / (OS_RATE * baud);
  endfunction
endpackage

// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: serial line, oversampling tick and received-byte outputs
interface uart_rx_os16_if #(parameter int DBIT = 8);
  logic rx;
  logic s_tick;
  logic [DBIT-1:0] dout;
  logic rx_done_tick;
  logic frame_err;
  logic parity_err;
  modport master(output rx, s_tick, input dout, rx_done_tick, frame_err, parity_err);
  modport slave(input rx, s_tick, output dout, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input with selectable reset value
module sync_2ff #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk) r_ff <= reset ? {2{RST_VAL}} : {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling 8N1 UART receiver; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input logic clk,
  input logic reset,
  uart_rx_os16_if.slave bus
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic w_rx;
  state_t r_state;
  logic [SW-1:0] r_s;
  logic [2:0] r_n;
  logic [DBIT-1:0] r_sh, r_dout;
  logic r_done, r_ferr;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .i_d(bus.rx), .o_q(w_rx));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s <= '0;
      r_n <= '0;
      r_sh <= '0;
      r_dout <= '0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (!w_rx) begin
          r_state <= START;
          r_s <= '0;
        end
        START: if (bus.s_tick) begin
          if (r_s == SW'(7)) begin
            r_state <= w_rx ? IDLE : DATA;
            r_s <= '0;
            r_n <= '0;
          end else r_s <= r_s + 1'b1;
        end
        DATA: if (bus.s_tick) begin
          if (r_s == SW'(15)) begin
            r_sh <= {w_rx, r_sh[DBIT-1:1]};
            r_s <= '0;
            r_n <= r_n + 1'b1;
            if (r_n == 3'(DBIT - 1)) r_state <= AFTER_DATA;
          end else r_s <= r_s + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bus.s_tick) begin
          if (r_s == SW'(15)) begin
            r_state <= STOP;
            r_s <= '0;
          end else r_s <= r_s + 1'b1;
        end
`endif
        STOP: if (bus.s_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            r_dout <= r_sh;
            r_ferr <= ~w_rx;
            r_done <= 1'b1;
            r_state <= IDLE;
            r_s <= '0;
          end else r_s <= r_s + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef UART_RX_PARITY_EN
  // parity is captured mid parity bit but published only with the done pulse
  logic r_par, r_perr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (r_state == PARITY && bus.s_tick && r_s == SW'(15)) r_par <= (^r_sh) ^ w_rx;
      if (r_state == STOP && bus.s_tick && r_s == SW'(SB_TICK - 1)) r_perr <= r_par;
    end
  end
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.dout = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err = r_ferr;
endmodule
